// File: rtl/sequential_divider.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock.
//
// Build option: define SEQ_DIV_SIGNED_EN for two's-complement operands
// (magnitudes on entry, sign correction on exit). Undefined: unsigned.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_ni       synchronous active-low reset
//   start_i        request a division, accepted only while idle
//   dividend_i     dividend, sampled on the accepting edge
//   divisor_i      divisor, sampled on the accepting edge
//   quotient_o     registered quotient, valid with done_o, held until next accept
//   remainder_o    registered remainder, valid with done_o, held until next accept
//   busy_o         high from the accepting edge through the done edge
//   done_o         single-cycle result-valid pulse
//   div_by_zero_o  divide-by-zero flag, updated with done_o, cleared on accept
module sequential_divider #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              div_by_zero_o
);

    localparam int unsigned     CntW    = $clog2(DATA_W);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] r_q, r_d;        // partial remainder, always < divisor
    logic [DATA_W-1:0] q_q, q_d;        // dividend shifts out as quotient shifts in
    logic [DATA_W-1:0] dvsr_q, dvsr_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;

    logic [DATA_W-1:0] mag_a, mag_b, quot_fix, rem_fix;
    logic [DATA_W:0]   r_shift;
    logic [DATA_W-1:0] r_sub;
    logic              r_ge;

`ifdef SEQ_DIV_SIGNED_EN
    logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;

    // Most-negative input maps to 2^(DATA_W-1), which is still a valid magnitude.
    assign mag_a    = dividend_i[DATA_W-1] ? -dividend_i : dividend_i;
    assign mag_b    = divisor_i[DATA_W-1] ? -divisor_i : divisor_i;
    assign quot_fix = neg_q_q ? -q_q : q_q;
    assign rem_fix  = neg_r_q ? -r_q : r_q;
    assign neg_q_d  = (state_q == StIdle && start_i) ?
                      (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]) : neg_q_q;
    assign neg_r_d  = (state_q == StIdle && start_i) ? dividend_i[DATA_W-1] : neg_r_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
        end
    end
`else
    assign mag_a    = dividend_i;
    assign mag_b    = divisor_i;
    assign quot_fix = q_q;
    assign rem_fix  = r_q;
`endif

    // The shifted remainder needs DATA_W+1 bits; the difference always fits DATA_W.
    assign r_shift = {r_q, q_q[DATA_W-1]};
    assign r_ge    = (r_shift >= {1'b0, dvsr_q});
    assign r_sub   = r_shift[DATA_W-1:0] - dvsr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    zero_d  = (divisor_i == '0);
                    dvsr_d  = mag_b;
                    // On divide-by-zero keep the raw dividend; it becomes the remainder.
                    q_d     = zero_d ? dividend_i : mag_a;
                    r_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                    state_d = zero_d ? StFinish : StCalc;
                end
            end
            StCalc: begin
                r_d   = r_ge ? r_sub : r_shift[DATA_W-1:0];
                q_d   = {q_q[DATA_W-2:0], r_ge};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                quot_d  = zero_q ? '1 : quot_fix;
                rem_d   = zero_q ? q_q : rem_fix;
                dbz_d   = zero_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvsr_q  <= dvsr_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed testbench for sequential_divider (DATA_W = 32). Follows the
// SEQ_DIV_SIGNED_EN build option of the design for the signed vectors.
module tb_sequential_divider;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic [W-1:0] quotient, remainder;
    logic         busy, done, dz;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] prev_q = '0;
    logic [W-1:0] prev_r = '0;

    always #5 clk = ~clk;

    sequential_divider #(.DATA_W(W)) dut (
        .clk_i         (clk),
        .reset_ni      (reset_n),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .busy_o        (busy),
        .done_o        (done),
        .div_by_zero_o (dz)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One operation: start on an edge, follow it to done, check timing and results.
    // poke re-asserts start with other operands while busy; they must be ignored.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int lat, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edz, input bit poke);
        int n;
        int bcnt;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".dz_clr"}, {31'b0, dz}, '0);
        n    = 0;
        bcnt = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy === 1'b1) bcnt++;
            if (n == 2) chk({tag, ".q_hold_calc"}, quotient, prev_q);
            if (poke && n == 3) begin
                dividend = 32'd50;
                divisor  = 32'd5;
                start    = 1'b1;
            end
            if (poke && n == 4) start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(lat));
        chk({tag, ".busy_cycles"}, 32'(bcnt), 32'(lat));
        chk({tag, ".busy_at_done"}, {31'b0, busy}, '0);
        chk({tag, ".quotient"}, quotient, eq);
        chk({tag, ".remainder"}, remainder, er);
        chk({tag, ".div_by_zero"}, {31'b0, dz}, {31'b0, edz});
        prev_q = eq;
        prev_r = er;
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, {31'b0, done}, '0);
        chk({tag, ".r_held"}, remainder, er);
    endtask

    initial begin
        int dcount;
        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.quotient", quotient, '0);
        chk("rst.remainder", remainder, '0);
        chk("rst.flags", {29'b0, busy, done, dz}, '0);
        @(negedge clk);
        reset_n = 1'b1;

        run_div("u100_7", 32'd100, 32'd7, W + 1, 32'd14, 32'd2, 1'b0, 1'b0);
        run_div("dbz", 32'h12345678, 32'h0, 1, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0);
        run_div("ffff_1", 32'hFFFFFFFF, 32'd1, W + 1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
        run_div("u5_9", 32'd5, 32'd9, W + 1, 32'd0, 32'd5, 1'b0, 1'b0);
`ifdef SEQ_DIV_SIGNED_EN
        run_div("sneg_pos", 32'hFFFFFF9C, 32'd7, W + 1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_div("spos_neg", 32'd100, 32'hFFFFFFF9, W + 1, 32'hFFFFFFF2, 32'd2, 1'b0, 1'b0);
        run_div("sneg_neg", 32'hFFFFFF9C, 32'hFFFFFFF9, W + 1, 32'd14, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_div("s_ovf", 32'h80000000, 32'hFFFFFFFF, W + 1, 32'h80000000, 32'h0, 1'b0, 1'b0);
`else
        run_div("u_big", 32'h80000000, 32'hFFFFFFFF, W + 1, 32'h0, 32'h80000000, 1'b0, 1'b0);
        run_div("u_half", 32'hFFFFFFFE, 32'h80000000, W + 1, 32'd1, 32'h7FFFFFFE, 1'b0, 1'b0);
`endif
        run_div("busy_poke", 32'd100, 32'd7, W + 1, 32'd14, 32'd2, 1'b0, 1'b1);

        // Abort an operation after its 10th iteration; no done may follow.
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd10;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst.quotient", quotient, '0);
        chk("midrst.remainder", remainder, '0);
        chk("midrst.flags", {29'b0, busy, done, dz}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        dcount  = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dcount++;
        end
        chk("midrst.no_done", 32'(dcount), '0);
        prev_q = '0;
        prev_r = '0;
        run_div("after_rst", 32'd1000, 32'd10, W + 1, 32'd100, 32'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
